// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: widths, opcodes, FSM states.
package alu_cmd_issuer_pkg;

  localparam int DATA_W_DEF = 16;

  // ALU opcode encodings
  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_ADDINC = 3'd1;
  localparam logic [2:0] OP_SUBDEC = 3'd2;
  localparam logic [2:0] OP_SUB    = 3'd3;
  localparam logic [2:0] OP_PASSA  = 3'd4;
  localparam logic [2:0] OP_INCA   = 3'd5;
  localparam logic [2:0] OP_DECA   = 3'd6;
  localparam logic [2:0] OP_PASSA2 = 3'd7;

  // Issuer FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of the settle counter able to hold 0..settle inclusive
  function automatic int settle_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_res_fifo.sv
// First-word-fall-through result FIFO. The head entry is visible on head_data
// whenever head_valid is high; a push and a pop in the same cycle are both
// honoured. Pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_issuer_res_fifo
  import alu_cmd_issuer_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop: pop only when non-empty, push only when space (or a pop frees it)
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != {CW{1'b0}})) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != CW'(DEPTH)) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage array write; contents need no reset because the head is gated by valid
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, forced to zero while empty so stale entries never leak out
  always_comb begin
    head_valid = (count_r != {CW{1'b0}});
    if (head_valid) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {WIDTH{1'b0}};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts commands, drives registered operands onto the
// combinational ALU, waits a settle window, captures the result into a FWFT
// FIFO and supports chaining the previous result in as operand A.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W:0]   alu_y,
  input  logic              alu_co,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W:0]   res_y,
  output logic              res_co,
  output logic [2:0]        res_op,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam int EW  = DATA_W + 1 + 1 + 3;
  localparam int CW  = cnt_w(FIFO_DEPTH);
  localparam int CW1 = CW + 1;
  localparam int SW  = settle_w(SETTLE_CYC);

  state_t            state_r;
  state_t            state_next_s;
  logic [SW-1:0]     settle_r;
  logic [SW-1:0]     settle_next_s;
  logic              accept_s;
  logic              capture_s;
  logic              pop_s;
  logic              ready_next_s;
  logic [CW-1:0]     fifo_count_s;
  logic [CW1-1:0]    count_next_s;
  logic [EW-1:0]     head_data_s;
  logic              head_valid_s;
  logic [DATA_W-1:0] last_a_r;
  logic              cmd_ready_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [2:0]        alu_op_r;
  logic [15:0]       ops_done_r;

  assign pop_s = head_valid_s && res_ready;

  // FSM state and settle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      settle_r <= {SW{1'b0}};
    end else begin
      state_r  <= state_next_s;
      settle_r <= settle_next_s;
    end
  end

  // FSM next-state, accept and capture strobes
  always_comb begin
    state_next_s  = state_r;
    settle_next_s = settle_r;
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s      = 1'b1;
          settle_next_s = SW'(SETTLE_CYC);
          state_next_s  = ST_ISSUE;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (settle_r <= SW'(1)) begin
          settle_next_s = {SW{1'b0}};
          state_next_s  = ST_CAPTURE;
        end else begin
          settle_next_s = settle_r - SW'(1);
          state_next_s  = ST_ISSUE;
        end
      end
      ST_CAPTURE: begin
        capture_s    = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s  = ST_IDLE;
        settle_next_s = {SW{1'b0}};
      end
    endcase
  end

  // Next-cycle readiness: idle next cycle and room left after this cycle's push/pop
  always_comb begin
    count_next_s = {1'b0, fifo_count_s} + CW1'(capture_s) - CW1'(pop_s);
    ready_next_s = 1'b0;
    if ((state_next_s == ST_IDLE) && (count_next_s < CW1'(FIFO_DEPTH))) begin
      ready_next_s = 1'b1;
    end else begin
      ready_next_s = 1'b0;
    end
  end

  // Registered command-ready so it is clean low during and right after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_r <= 1'b0;
    end else begin
      cmd_ready_r <= ready_next_s;
    end
  end

  // ALU operand registers; all three change together on accept and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r  <= {DATA_W{1'b0}};
      alu_b_r  <= {DATA_W{1'b0}};
      alu_op_r <= 3'd0;
    end else if (accept_s) begin
      alu_a_r  <= cmd_chain ? last_a_r : cmd_a;
      alu_b_r  <= cmd_b;
      alu_op_r <= cmd_op;
    end
  end

  // Capture bookkeeping: last result for chaining and completed-operation count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a_r   <= {DATA_W{1'b0}};
      ops_done_r <= 16'd0;
    end else if (capture_s) begin
      last_a_r   <= alu_y[DATA_W-1:0];
      ops_done_r <= ops_done_r + 16'd1;
    end
  end

  alu_cmd_issuer_res_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (capture_s),
    .push_data  ({alu_y, alu_co, alu_op_r}),
    .pop        (pop_s),
    .head_data  (head_data_s),
    .head_valid (head_valid_s),
    .count      (fifo_count_s)
  );

  assign cmd_ready  = cmd_ready_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_op_r;
  assign busy       = (state_r != ST_IDLE);
  assign ops_done   = ops_done_r;
  assign res_valid  = head_valid_s;
  assign res_y      = head_data_s[EW-1:4];
  assign res_co     = head_data_s[3];
  assign res_op     = head_data_s[2:0];

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural model of the team ALU.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        cmd_chain;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [16:0] alu_y;
  logic        alu_co;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_y;
  logic        res_co;
  logic [2:0]  res_op;
  logic        busy;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] y;
    logic        co;
    logic [2:0]  op;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [16:0] y;
    logic        co;
  } vec_t;
  vec_t vecs [10];

  alu_cmd_issuer #(
    .DATA_W     (16),
    .FIFO_DEPTH (4),
    .SETTLE_CYC (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_chain  (cmd_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_y      (alu_y),
    .alu_co     (alu_co),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_y      (res_y),
    .res_co     (res_co),
    .res_op     (res_op),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team ALU model: y = sext(A) + sext(Bx) + cin, co = carry out of the 16-bit add
  logic [15:0] bop;
  logic        cin;
  logic [16:0] csum;
  always_comb begin
    bop = 16'd0;
    cin = 1'b0;
    case (alu_opcode)
      3'd0: bop = alu_b;
      3'd1: begin bop = alu_b; cin = 1'b1; end
      3'd2: bop = ~alu_b;
      3'd3: begin bop = ~alu_b; cin = 1'b1; end
      3'd5: cin = 1'b1;
      3'd6: bop = 16'hFFFF;
      default: bop = 16'd0;
    endcase
    alu_y  = {alu_a[15], alu_a} + {bop[15], bop} + {16'd0, cin};
    csum   = {1'b0, alu_a} + {1'b0, bop} + {16'd0, cin};
    alu_co = csum[16];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every popped head against the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %h want none", {res_y, res_co, res_op});
      end else begin
        check("result", 64'({res_y, res_co, res_op}),
              64'({sb_q[0].y, sb_q[0].co, sb_q[0].op}));
        void'(sb_q.pop_front());
      end
    end
  end

  // Present a command and wait (bounded) for acceptance; returns #1 after the accept edge
  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input logic chain, input bit push_exp,
                          input logic [16:0] ey, input logic eco);
    bit acc;
    exp_t e;
    acc       = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_chain = chain;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 want 1");
    end else if (push_exp) begin
      e.y  = ey;
      e.co = eco;
      e.op = op;
      sb_q.push_back(e);
    end
  endtask

  // Drain the FIFO with res_ready high until the scoreboard is empty (bounded)
  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    check("drain_no_valid", 64'(res_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{16'd5,     16'd3, 3'd0, 17'h00008, 1'b0};
    vecs[1] = '{16'd5,     16'd3, 3'd1, 17'h00009, 1'b0};
    vecs[2] = '{16'd5,     16'd3, 3'd2, 17'h00001, 1'b1};
    vecs[3] = '{16'd5,     16'd3, 3'd3, 17'h00002, 1'b1};
    vecs[4] = '{16'd5,     16'd3, 3'd4, 17'h00005, 1'b0};
    vecs[5] = '{16'd5,     16'd3, 3'd5, 17'h00006, 1'b0};
    vecs[6] = '{16'd5,     16'd3, 3'd6, 17'h00004, 1'b1};
    vecs[7] = '{16'd5,     16'd3, 3'd7, 17'h00005, 1'b0};
    vecs[8] = '{16'hFFFF,  16'd1, 3'd3, 17'h1FFFE, 1'b1};
    vecs[9] = '{16'h7FFF,  16'd1, 3'd0, 17'h08000, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 16'd0; cmd_b = 16'd0;
    cmd_op = 3'd0; cmd_chain = 1'b0; res_ready = 1'b0;
    #12;
    check("rst_alu", 64'({alu_a, alu_b, alu_opcode}), 64'd0);
    check("rst_flags", 64'({cmd_ready, res_valid, busy}), 64'd0);
    check("rst_res", 64'({res_y, res_co, res_op}), 64'd0);
    check("rst_ops", 64'(ops_done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Basic add with latency checks
    send_cmd(16'd5, 16'd3, 3'd0, 1'b0, 1'b1, 17'h00008, 1'b0);
    check("issue_alu", 64'({alu_a, alu_b, alu_opcode}), 64'({16'd5, 16'd3, 3'd0}));
    check("issue_busy", 64'({busy, cmd_ready, res_valid}), 64'({1'b1, 1'b0, 1'b0}));
    @(posedge clk); #1;
    check("valid_n1", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    check("valid_n2", 64'(res_valid), 64'd1);
    check("basic_res", 64'({res_y, res_co, res_op}), 64'({17'h00008, 1'b0, 3'd0}));
    check("basic_ops", 64'(ops_done), 64'd1);
    check("idle_hold", 64'({alu_a, busy, cmd_ready}), 64'({16'd5, 1'b0, 1'b1}));

    // Table-driven opcode sweep and carry/sign vectors
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b1, vecs[i].y, vecs[i].co);
    end
    drain();
    check("sweep_ops", 64'(ops_done), 64'd11);

    // Chain mode
    send_cmd(16'd10, 16'd4, 3'd0, 1'b0, 1'b1, 17'd14, 1'b0);
    send_cmd(16'h0BAD, 16'd2, 3'd3, 1'b1, 1'b1, 17'd12, 1'b1);
    check("chain_alu_a", 64'(alu_a), 64'd14);
    drain();

    // Backpressure: fill the FIFO, fifth command must wait
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(16'(100 + i), 16'd1, 3'd0, 1'b0, 1'b1, 17'(101 + i), 1'b0);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("full_ready", 64'({cmd_ready, res_valid, busy}), 64'({1'b0, 1'b1, 1'b0}));
    cmd_a = 16'd200; cmd_b = 16'd1; cmd_op = 3'd0; cmd_chain = 1'b0; cmd_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("fifth_waits", 64'({busy, cmd_ready}), 64'd0);
    check("full_ops", 64'(ops_done), 64'd17);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("ready_after_pop", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("fifth_accepted", 64'({busy, alu_a}), 64'({1'b1, 16'd200}));
    sb_q.push_back('{17'd201, 1'b0, 3'd0});
    @(posedge clk); #1;
    check("full_again", 64'(cmd_ready), 64'd0);

    // Simultaneous push and pop leaves occupancy unchanged
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    send_cmd(16'd300, 16'd1, 3'd0, 1'b0, 1'b1, 17'd301, 1'b0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("pushpop_ready", 64'({cmd_ready, res_valid}), 64'({1'b1, 1'b1}));
    check("pushpop_sb", 64'(sb_q.size()), 64'd3);
    check("pushpop_ops", 64'(ops_done), 64'd19);
    drain();

    // Reset during ISSUE discards the operation and empties the FIFO
    res_ready = 1'b0;
    send_cmd(16'd7, 16'd7, 3'd0, 1'b0, 1'b1, 17'd14, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_valid", 64'(res_valid), 64'd1);
    send_cmd(16'd1, 16'd1, 3'd0, 1'b0, 1'b0, 17'd0, 1'b0);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("mid_rst_alu", 64'({alu_a, alu_b, alu_opcode}), 64'd0);
    check("mid_rst_flags", 64'({cmd_ready, res_valid, busy}), 64'd0);
    check("mid_rst_res", 64'({res_y, res_co, res_op}), 64'd0);
    check("mid_rst_ops", 64'(ops_done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("post_rst_quiet", 64'({res_valid, busy}), 64'd0);
    check("post_rst_ops", 64'(ops_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
